// File: rtl/fifo_drain.sv
// fifo_drain: read-side controller for the fifo buffer, running in the fifo read clock domain.
// It watches the fifo status level and, once a burst is triggered, pops words with a registered
// strobe (pop_o, wired to the fifo clk_o). Each popped word goes into a 2-entry output buffer
// that is presented downstream on a valid/ready stream.
// Optional feature: define FIFO_DRAIN_TIMEOUT_EN to also start a burst after t idle cycles with
// a nonzero status.
module fifo_drain #(
   parameter int unsigned n  = 8,
   parameter logic [2:0]  wm = 3'b011,
   parameter int unsigned t  = 256
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [2:0]   status,
   input  logic [n-1:0] data_o,
   output logic         pop_o,
   input  logic         flush,
   output logic [n-1:0] m_data,
   output logic         m_valid,
   input  logic         m_ready,
   output logic         busy
);

   typedef enum logic [0:0] {StIdle, StDrain} state_e;

   // t only matters for the timeout, but a value below 2 is always a configuration error.
   if (t < 2) begin : g_bad_t
      $error("fifo_drain: t must be at least 2");
   end

   state_e         state_q, state_d;
   logic           pop_q, pop_d;
   logic [1:0]     occ_q, occ_d;
   logic [n-1:0]   head_q, head_d;
   logic [n-1:0]   tail_q, tail_d;

   logic           st_nz;
   logic           timeout;
   logic           trigger;
   logic           capture;
   logic           xfer;

   assign st_nz   = (status != 3'b000);
   // A pop issued on the previous edge means the fifo presents its word at this edge.
   assign capture = pop_q;
   assign xfer    = m_valid & m_ready;
   assign trigger = (status >= wm) | (flush & st_nz) | timeout;

`ifdef FIFO_DRAIN_TIMEOUT_EN
   localparam int unsigned     TimerW   = $clog2(t + 1);
   localparam logic [TimerW-1:0] TimerMax = TimerW'(t);

   logic [TimerW-1:0] timer_q, timer_d;

   assign timeout = (timer_q == TimerMax);

   // Idle timer: counts nonzero-status cycles in IDLE, saturates at t, clears on empty or burst.
   always_comb begin
      timer_d = timer_q;
      if ((state_q != StIdle) || !st_nz || (state_d == StDrain)) begin
         timer_d = '0;
      end else if (timer_q != TimerMax) begin
         timer_d = timer_q + TimerW'(1);
      end
   end

   // Timer register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   // Burst FSM and pop strobe; decisions are only taken when no pop is in flight.
   always_comb begin
      state_d = state_q;
      pop_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (trigger) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (!pop_q) begin
               if (!st_nz) begin
                  state_d = StIdle;
               end else if (occ_q < 2'd2) begin
                  pop_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output buffer: head is always what m_data shows; tail holds the second word if present.
   always_comb begin
      occ_d  = occ_q;
      head_d = head_q;
      tail_d = tail_q;
      unique case ({capture, xfer})
         2'b10: begin
            if (occ_q == 2'd0) begin
               head_d = data_o;
            end else begin
               tail_d = data_o;
            end
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            // Leaving head untouched on the last transfer keeps m_data at its final value.
            if (occ_q == 2'd2) begin
               head_d = tail_q;
            end
            occ_d = occ_q - 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd2) begin
               head_d = tail_q;
               tail_d = data_o;
            end else begin
               head_d = data_o;
            end
         end
         default: ;
      endcase
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         pop_q   <= 1'b0;
         occ_q   <= 2'd0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         pop_q   <= pop_d;
         occ_q   <= occ_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   assign pop_o   = pop_q;
   assign m_data  = head_q;
   assign m_valid = (occ_q != 2'd0);
   assign busy    = (state_q == StDrain);

endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: self-checking bench for fifo_drain with a behavioural 8-deep fifo model
// that pops on the rising edge of pop_o, and a scoreboard of words in push order.
module tb_fifo_drain;

   localparam int unsigned N = 8;
   localparam int unsigned T = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [2:0]   status;
   logic [N-1:0] fifo_dout = '0;
   logic         pop_o;
   logic         flush = 1'b0;
   logic [N-1:0] m_data;
   logic         m_valid;
   logic         m_ready = 1'b1;
   logic         busy;

   fifo_drain #(.n(N), .wm(3'b011), .t(T)) dut (
      .clk     (clk),
      .rst     (rst),
      .status  (status),
      .data_o  (fifo_dout),
      .pop_o   (pop_o),
      .flush   (flush),
      .m_data  (m_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .busy    (busy)
   );

   initial forever #5 clk = ~clk;

   // fifo model: words[] holds everything ever pushed; wr_cnt/rd_cnt give occupancy.
   logic [N-1:0] words[$];
   int           wr_cnt = 0;
   int           rd_cnt = 0;

   function automatic logic [2:0] lvl(input int c);
      if (c <= 0) return 3'b000;
      else if (c <= 2) return 3'b001;
      else if (c <= 4) return 3'b011;
      else if (c <= 6) return 3'b101;
      else return 3'b111;
   endfunction

   assign status = lvl(wr_cnt - rd_cnt);

   always @(posedge pop_o) begin
      fifo_dout <= words[rd_cnt];
      rd_cnt    <= rd_cnt + 1;
   end

   typedef struct {
      int nload;
      bit flush;
      bit ready;
      bit trig;
      int stall_pops;
   } vec_t;

   vec_t         vecs[8];
   logic [N-1:0] exp_q[$];
   logic [N-1:0] abc[3];
   int           n_tests = 0;
   int           n_fail  = 0;
   int           pop_cnt = 0;
   bit           pop_prev = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic load(input logic [N-1:0] w);
      words.push_back(w);
      exp_q.push_back(w);
      wr_cnt++;
   endtask

   // One clock: observe at the falling edge, then return just after the next rising edge.
   task automatic tick();
      @(negedge clk);
      if (pop_o) begin
         pop_cnt++;
         chk("pop_gap", {31'd0, pop_prev}, 32'd0);
      end
      pop_prev = pop_o;
      if (m_valid && m_ready) begin
         if (exp_q.size() == 0) chk("sb_extra_word", {24'd0, m_data}, 32'hFFFF_FFFF);
         else chk("sb_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      bit done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         tick();
         if (status == 3'b000 && !busy && !m_valid && !pop_o) done = 1'b1;
      end
      chk(name, {31'd0, done}, 32'd1);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      logic [N-1:0] last = '0;
      pop_cnt = 0;
      for (int k = 0; k < v.nload; k++) begin
         last = (idx == 0 && k < 3) ? abc[k] : N'($urandom_range(255));
         load(last);
      end
      m_ready = v.ready;
      if (v.flush) begin
         flush = 1'b1;
         tick();
         flush = 1'b0;
      end
      if (!v.trig) begin
         repeat (12) tick();
         chk("vec_no_trigger", pop_cnt, 0);
         flush = 1'b1;
         tick();
         flush = 1'b0;
      end
      if (!v.ready) begin
         repeat (20) tick();
         chk("vec_stall_pops", pop_cnt, v.stall_pops);
         m_ready = 1'b1;
      end
      wait_idle("vec_drain_done");
      chk("vec_all_delivered", exp_q.size(), 0);
      chk("vec_pop_total", pop_cnt, v.nload);
      chk("vec_m_data_hold", {24'd0, m_data}, {24'd0, last});
   endtask

   initial begin
      bit found;
      int first;

      abc = '{8'hA1, 8'hB2, 8'hC3};
      //         nload flush ready trig stall
      vecs[0] = '{3, 1'b0, 1'b1, 1'b1, 0};
      vecs[1] = '{5, 1'b0, 1'b0, 1'b1, 2};
      vecs[2] = '{1, 1'b1, 1'b1, 1'b1, 0};
      vecs[3] = '{2, 1'b0, 1'b1, 1'b0, 0};
      vecs[4] = '{8, 1'b0, 1'b1, 1'b1, 0};
      vecs[5] = '{4, 1'b0, 1'b0, 1'b1, 2};
      vecs[6] = '{2, 1'b0, 1'b0, 1'b0, 2};
      vecs[7] = '{1, 1'b0, 1'b0, 1'b0, 1};

      #12;
      chk("rst_pop_o", {31'd0, pop_o}, 32'd0);
      chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_m_data", {24'd0, m_data}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

      // Two words below the watermark, held a long time without flush.
      pop_cnt = 0;
      first   = 0;
      load(8'h11);
      load(8'h22);
      for (int i = 1; i <= 1000; i++) begin
         tick();
         if (pop_cnt != 0 && first == 0) first = i;
      end
`ifdef FIFO_DRAIN_TIMEOUT_EN
      chk("timeout_first_pop", first, T + 3);
`else
      chk("below_wm_no_pop", pop_cnt, 0);
`endif
      load(8'h33);
      tick();
      tick();
`ifndef FIFO_DRAIN_TIMEOUT_EN
      chk("wm_reached_busy", {31'd0, busy}, 32'd1);
`endif
      wait_idle("wm_drain_done");
      chk("wm_all_delivered", exp_q.size(), 0);

      // Asynchronous reset while the second pop of a stalled burst is in flight.
      m_ready = 1'b0;
      for (int k = 0; k < 5; k++) load(N'(8'h50 + k));
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         if (pop_o && m_valid) found = 1'b1;
      end
      chk("rst_setup_reached", {31'd0, found}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_pop_o", {31'd0, pop_o}, 32'd0);
      chk("async_rst_m_valid", {31'd0, m_valid}, 32'd0);
      chk("async_rst_busy", {31'd0, busy}, 32'd0);
      chk("async_rst_m_data", {24'd0, m_data}, 32'd0);
      exp_q.delete();
      for (int k = rd_cnt; k < wr_cnt; k++) exp_q.push_back(words[k]);
      pop_prev = 1'b0;
      @(posedge clk);
      #1;
      rst     = 1'b0;
      m_ready = 1'b1;
      wait_idle("post_rst_drain_done");
      chk("post_rst_all_delivered", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
